cache_tag_store: RTL

- Parametrised N-way set-associative tag store for the cache controller, replacing the fixed 4-way, FIFO-only tag memory.
- Adds per-line dirty bits, a selectable replacement policy (FIFO or true LRU), and explicit operations: read lookup, write lookup, fill and invalidate.
- Adds a valid/ready request port with a registered 1-cycle response, and a sequential clear sweep used after reset and on flush.
- Sits between the cache control FSM and the data array. The control FSM uses the response to pick the data way and to decide on writeback.

---
 rtl/cache_tag_store.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_store.sv
// N-way set-associative tag store with dirty bits, FIFO or LRU replacement,
// a one-cycle registered lookup response and a sequential clear sweep.
module cache_tag_store #(
  parameter int unsigned TAG_SIZE   = 5,
  parameter int unsigned INDEX_SIZE = 8,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned WAY_W      = 2,
  parameter int unsigned REPL_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [TAG_SIZE-1:0]   req_tag,
  input  logic [INDEX_SIZE-1:0] req_index,
  input  logic                  flush_start,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic                  rsp_victim_valid,
  output logic                  rsp_victim_dirty,
  output logic [TAG_SIZE-1:0]   rsp_victim_tag,
  output logic [WAY_W-1:0]      rsp_victim_way
);

  localparam int unsigned SETS = 1 << INDEX_SIZE;

  typedef enum logic {CLEAR, IDLE} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_FILL = 2'b10, OP_INVAL = 2'b11} op_e;

  state_e                state_q;
  logic [INDEX_SIZE-1:0] clr_cnt_q;

  logic [TAG_SIZE-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];
  logic [WAY_W-1:0]    fifo_q  [SETS];

  logic                rsp_valid_q, rsp_hit_q, rsp_vvalid_q, rsp_vdirty_q;
  logic [WAY_W-1:0]    rsp_way_q, rsp_vway_q;
  logic [TAG_SIZE-1:0] rsp_vtag_q;

  op_e                 op;
  logic                accept;
  logic                hit, inv_found, full;
  logic [WAY_W-1:0]    hit_way, inv_way, lru_way, victim_way, tgt_way, touch_way;
  logic                touch, tag_we;
  logic [WAYS-1:0]     valid_row_d, dirty_row_d;
  logic [WAY_W-1:0]    age_row_d [WAYS];
  logic [WAY_W-1:0]    fifo_d;
  logic [WAY_W-1:0]    vic_way_d, rsp_way_d;
  logic                vic_en, vic_valid_d, vic_dirty_d;
  logic [TAG_SIZE-1:0] vic_tag_d;

  assign op        = op_e'(req_op);
  assign req_ready = (state_q == IDLE) && !flush_start;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == CLEAR);

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_victim_valid = rsp_vvalid_q;
  assign rsp_victim_dirty = rsp_vdirty_q;
  assign rsp_victim_tag   = rsp_vtag_q;
  assign rsp_victim_way   = rsp_vway_q;

  // Lookup: lowest matching way wins, lowest invalid way is preferred as victim.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[req_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[req_index][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    full = !inv_found;
    if (!full)               victim_way = inv_way;
    else if (REPL_MODE == 1) victim_way = lru_way;
    else                     victim_way = fifo_q[req_index];
  end

  always_comb begin
    valid_row_d = valid_q[req_index];
    dirty_row_d = dirty_q[req_index];
    fifo_d      = fifo_q[req_index];
    for (int unsigned w = 0; w < WAYS; w++) age_row_d[w] = age_q[req_index][w];
    tag_we    = 1'b0;
    touch     = 1'b0;
    touch_way = hit_way;
    tgt_way   = hit ? hit_way : victim_way;
    vic_way_d = victim_way;
    vic_en    = 1'b1;
    rsp_way_d = hit_way;
    case (op)
      OP_READ:  touch = hit;
      OP_WRITE: begin
        if (hit) begin
          dirty_row_d[hit_way] = 1'b1;
          touch                = 1'b1;
        end
      end
      OP_FILL: begin
        tag_we               = 1'b1;
        valid_row_d[tgt_way] = 1'b1;
        if (!hit) dirty_row_d[tgt_way] = 1'b0;
        touch     = 1'b1;
        touch_way = tgt_way;
        if (!hit && full) fifo_d = fifo_q[req_index] + WAY_W'(1);
        vic_way_d = tgt_way;
        rsp_way_d = tgt_way;
      end
      OP_INVAL: begin
        vic_way_d = hit_way;
        vic_en    = hit;
        if (hit) begin
          valid_row_d[hit_way] = 1'b0;
          dirty_row_d[hit_way] = 1'b0;
        end
      end
      default: ;
    endcase
    // Ages younger than the touched way shift up by one, keeping a permutation.
    if (touch && (REPL_MODE == 1)) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_index][w] < age_q[req_index][touch_way])
          age_row_d[w] = age_q[req_index][w] + WAY_W'(1);
      end
      age_row_d[touch_way] = '0;
    end
    vic_valid_d = vic_en && valid_q[req_index][vic_way_d];
    vic_dirty_d = vic_en && dirty_q[req_index][vic_way_d];
    vic_tag_d   = vic_en ? tag_q[req_index][vic_way_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      valid_q[clr_cnt_q] <= '0;
      dirty_q[clr_cnt_q] <= '0;
      for (int unsigned w = 0; w < WAYS; w++) age_q[clr_cnt_q][w] <= WAY_W'(w);
    end else if (accept) begin
      valid_q[req_index] <= valid_row_d;
      dirty_q[req_index] <= dirty_row_d;
      for (int unsigned w = 0; w < WAYS; w++) age_q[req_index][w] <= age_row_d[w];
      if (tag_we) tag_q[req_index][tgt_way] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      for (int unsigned s = 0; s < SETS; s++) fifo_q[s] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_vvalid_q <= 1'b0;
      rsp_vdirty_q <= 1'b0;
      rsp_vtag_q   <= '0;
      rsp_vway_q   <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_hit_q    <= hit;
        rsp_way_q    <= rsp_way_d;
        rsp_vvalid_q <= vic_valid_d;
        rsp_vdirty_q <= vic_dirty_d;
        rsp_vtag_q   <= vic_tag_d;
        rsp_vway_q   <= vic_way_d;
      end
      case (state_q)
        CLEAR: begin
          fifo_q[clr_cnt_q] <= '0;
          clr_cnt_q         <= clr_cnt_q + INDEX_SIZE'(1);
          if (clr_cnt_q == '1) state_q <= IDLE;
        end
        IDLE: begin
          if (flush_start) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end else if (accept) begin
            fifo_q[req_index] <= fifo_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule
